// File: rtl/cond_flags.sv
// Condition-code producer: counts outstanding flag-setting instructions,
// latches Zero/Pos/Neg from written-back results and stalls branches on stale flags.
module cond_flags #(
    parameter int WIDTH   = 16,
    parameter int OUT_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_opcode,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             br_query,
    input  logic             flush,
    output logic             Zero,
    output logic             Pos,
    output logic             Neg,
    output logic             flags_pending,
    output logic             br_stall,
    output logic             err
);
    localparam int CW = $clog2(OUT_MAX + 1);

    typedef enum logic {
        READY   = 1'b0,
        PENDING = 1'b1
    } state_t;

    function automatic logic flag_setting(input logic [4:0] op);
        return (op[4:3] == 2'b00) | (op[4:2] == 3'b010);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;
    logic          pos_q, pos_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;
    logic          set_issue_s;

    assign issue_ready   = (cnt_q < CW'(OUT_MAX)) | wb_valid;
    assign set_issue_s   = issue_valid & flag_setting(issue_opcode) & issue_ready;
    assign flags_pending = (state_q == PENDING);
    assign br_stall      = br_query & flags_pending;
    assign Zero          = zero_q;
    assign Pos           = pos_q;
    assign Neg           = neg_q;
    assign err           = err_q;

    // Next-state: counter, flags, sticky error and pending FSM
    always_comb begin
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        err_d   = err_q;
        state_d = state_q;

        // flush wins over a same-cycle issue; a matched issue+writeback nets to zero
        if (flush) begin
            cnt_d = '0;
        end else if (set_issue_s && !wb_valid) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!set_issue_s && wb_valid && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (wb_valid) begin
            zero_d = (wb_result == '0);
            neg_d  = wb_result[WIDTH-1];
            pos_d  = ~zero_d & ~neg_d;
        end else begin
            zero_d = zero_q;
            neg_d  = neg_q;
            pos_d  = pos_q;
        end

        if (wb_valid && (cnt_q == '0) && !set_issue_s && !flush) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            READY:   state_d = (cnt_d != '0) ? PENDING : READY;
            PENDING: state_d = (cnt_d == '0) ? READY : PENDING;
            default: state_d = READY;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= READY;
            cnt_q   <= '0;
            zero_q  <= 1'b1;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cond_flags.sv
// Directed-vector bench for cond_flags: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cond_flags;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_opcode;
    logic        issue_ready;
    logic        wb_valid;
    logic [15:0] wb_result;
    logic        br_query;
    logic        flush;
    logic        Zero, Pos, Neg, flags_pending, br_stall, err;

    int checks = 0;
    int errors = 0;

    string      name_q[$];
    logic [6:0] exp_q[$];
    logic [6:0] mask_q[$];

    cond_flags #(.WIDTH(16), .OUT_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_result(wb_result),
        .br_query(br_query), .flush(flush),
        .Zero(Zero), .Pos(Pos), .Neg(Neg),
        .flags_pending(flags_pending), .br_stall(br_stall), .err(err)
    );

    always #5 clk = ~clk;

    // Output vector order: {issue_ready, br_stall, err, flags_pending, Neg, Pos, Zero}
    always @(negedge clk) begin
        if (name_q.size() > 0) begin
            string      nm;
            logic [6:0] ex, mk, act;
            nm  = name_q.pop_front();
            ex  = exp_q.pop_front();
            mk  = mask_q.pop_front();
            act = {issue_ready, br_stall, err, flags_pending, Neg, Pos, Zero};
            if (mk != 7'b0) begin
                checks++;
                if (((act ^ ex) & mk) != 7'b0) begin
                    errors++;
                    $display("FAIL %s: got rdy/stall/err/pend/N/P/Z=%b expected %b (mask %b)",
                             nm, act, ex, mk);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic iv, input logic [4:0] op,
                       input logic wb, input logic [15:0] res, input logic brq,
                       input logic fl, input string nm, input logic [6:0] ex,
                       input logic [6:0] mk);
        @(posedge clk);
        #1;
        rst_n        = rst;
        issue_valid  = iv;
        issue_opcode = op;
        wb_valid     = wb;
        wb_result    = res;
        br_query     = brq;
        flush        = fl;
        name_q.push_back(nm);
        exp_q.push_back(ex);
        mask_q.push_back(mk);
    endtask

    localparam logic [6:0] ALL = 7'b1111111;

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_opcode = 5'd0; wb_valid = 1'b0;
        wb_result = 16'h0000; br_query = 1'b0; flush = 1'b0;

        // reset
        cyc(1'b0, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "rst0",        7'b0000000, 7'b0000000);
        cyc(1'b0, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b1, 1'b0, "reset_state", 7'b1000001, ALL);
        // issue, stall, negative writeback
        cyc(1'b1, 1'b1, 5'h02, 1'b0, 16'h0000, 1'b1, 1'b0, "issue1",      7'b1000001, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b1, 1'b0, "stall_c2",    7'b1101001, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 1'b1, 1'b0, "stall_c3",    7'b1101001, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b1, 1'b0, "neg_c4",      7'b1000100, ALL);
        // fill to OUT_MAX
        cyc(1'b1, 1'b1, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "fill1",       7'b1000100, ALL);
        cyc(1'b1, 1'b1, 5'h07, 1'b0, 16'h0000, 1'b0, 1'b0, "fill2",       7'b1001100, ALL);
        cyc(1'b1, 1'b1, 5'h0B, 1'b0, 16'h0000, 1'b0, 1'b0, "fill3",       7'b1001100, ALL);
        cyc(1'b1, 1'b1, 5'h01, 1'b0, 16'h0000, 1'b0, 1'b0, "full_refuse", 7'b0001100, ALL);
        cyc(1'b1, 1'b1, 5'h01, 1'b1, 16'h0005, 1'b0, 1'b0, "full_wb_rdy", 7'b1001100, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "pos_cnt3",    7'b0001010, ALL);
        // drain
        cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'h0001, 1'b0, 1'b0, "drain3",      7'b1001010, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'h0001, 1'b0, 1'b0, "drain2",      7'b1001010, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'h0001, 1'b0, 1'b0, "drain1",      7'b1001010, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "drained",     7'b1000010, ALL);
        // non-flag-setting opcodes
        cyc(1'b1, 1'b1, 5'h0C, 1'b0, 16'h0000, 1'b0, 1'b0, "branch_op",   7'b1000010, ALL);
        cyc(1'b1, 1'b1, 5'h12, 1'b0, 16'h0000, 1'b0, 1'b0, "op10010",     7'b1000010, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "no_pend",     7'b1000010, ALL);
        // flush with writeback and issue, cnt=2
        cyc(1'b1, 1'b1, 5'h01, 1'b0, 16'h0000, 1'b0, 1'b0, "pre_fl1",     7'b1000010, ALL);
        cyc(1'b1, 1'b1, 5'h08, 1'b0, 16'h0000, 1'b0, 1'b0, "pre_fl2",     7'b1001010, ALL);
        cyc(1'b1, 1'b1, 5'h03, 1'b1, 16'h0000, 1'b1, 1'b1, "flush_cyc",   7'b1101010, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b1, 1'b0, "post_flush",  7'b1000001, ALL);
        // spurious writeback with cnt=0
        cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'hFFFF, 1'b0, 1'b0, "spur_wb",     7'b1000001, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "err_set",     7'b1010100, ALL);
        cyc(1'b1, 1'b1, 5'h04, 1'b0, 16'h0000, 1'b0, 1'b0, "err_sticky1", 7'b1010100, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'h0002, 1'b1, 1'b0, "err_sticky2", 7'b1111100, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "err_sticky3", 7'b1010010, ALL);
        // reset clears err; reset mid-operation ignores writeback
        cyc(1'b0, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "rst_again",   7'b1010010, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "err_cleared", 7'b1000001, ALL);
        cyc(1'b1, 1'b1, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, "mid_issue",   7'b1000001, ALL);
        cyc(1'b0, 1'b0, 5'h00, 1'b1, 16'h8000, 1'b0, 1'b0, "mid_rst",     7'b1001001, ALL);
        cyc(1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b1, 1'b0, "after_rst",   7'b1000001, ALL);

        for (int i = 0; i < 20 && name_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (name_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", name_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cond_flags.md
# cond_flags

Condition-code producer for the single-cycle/multi-cycle datapath. Tracks outstanding flag-setting ALU instructions, latches Zero/Pos/Neg from each written-back result, and tells decode when branch flags are stale. Sits between the ALU writeback path and the branch-condition logic, which consumes `Zero`, `Pos` and `Neg`.

## Interface
- `WIDTH`, 16, ALU result width in bits.
- `OUT_MAX`, 3, maximum outstanding flag-setting instructions; 1..7.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `issue_valid`  in  1  an instruction issues this cycle.
- `issue_opcode`  in  5  opcode of the issuing instruction.
- `issue_ready`  out  1  a flag-setting issue is accepted this cycle.
- `wb_valid`  in  1  a flag-setting result is written back this cycle.
- `wb_result`  in  WIDTH  result being written back.
- `br_query`  in  1  a branch in decode needs flags this cycle.
- `flush`  in  1  discard all in-flight flag-setters.
- `Zero`  out  1  last result == 0.
- `Pos`  out  1  last result > 0, signed.
- `Neg`  out  1  last result < 0, signed.
- `flags_pending`  out  1  outstanding count != 0.
- `br_stall`  out  1  branch must wait.
- `err`  out  1  sticky protocol error.

## Operation
- Flag-setting opcodes: `issue_opcode[4:3]==2'b00` (00000–00111), or `issue_opcode[4:2]==3'b010` (01000–01011). Branches (011xx) and all 1xxxx opcodes do not set flags. They never touch the counter.
- `set_issue` = `issue_valid & flag_setting(issue_opcode) & issue_ready`.
- Outstanding counter `cnt`, width `$clog2(OUT_MAX+1)`, range 0..OUT_MAX.
  - `set_issue` only: +1.
  - `wb_valid` only, with `cnt>0`: −1.
  - Both in the same cycle: unchanged.
- `issue_ready` is combinational: `(cnt < OUT_MAX) | wb_valid`. When `cnt==OUT_MAX` and there is no writeback, a flag-setting issue is refused and upstream must hold it. Non-flag-setting issues ignore `issue_ready`.
- Flag latch on `wb_valid`:
  - `Zero <= (wb_result==0)`
  - `Neg <= wb_result[WIDTH-1]`
  - `Pos <= ~Zero_next & ~Neg_next`
  - Exactly one flag is high at all times.
- `wb_valid` with `cnt==0` and no same-cycle `set_issue`:
  - flags still latch;
  - `cnt` stays 0;
  - `err <= 1`.
- `err` clears only on reset.
- Overflow guard: `set_issue` can never push `cnt` above OUT_MAX, because `issue_ready` prevents it.
- `flush`:
  - `cnt <= 0` next cycle; this overrides any same-cycle `set_issue`, which is discarded.
  - A same-cycle `wb_valid` is still committed: flags latch, and no `err` is raised.
- FSM is derived from `cnt`:
  - READY: `cnt==0`.
  - PENDING: `cnt>0`.
  - READY→PENDING on a net increment. PENDING→READY when `cnt` goes 1→0, or on `flush`.
- `flags_pending` is registered and equals `(cnt!=0)`.
- `br_stall = br_query & flags_pending`, combinational from registered state.

## Timing
- Reset values (cycle after `rst_n` sampled low):
  - `Zero=1`, `Pos=0`, `Neg=0`
  - `cnt=0`, `flags_pending=0`, `err=0`
  - `issue_ready=1`; `br_stall=0` regardless of `br_query`.
- Reset mid-operation discards all outstanding state. A writeback in the reset cycle is ignored.
- Flag latency: `wb_valid` in cycle N → new flags visible in cycle N+1. No bypass; a branch in cycle N sees the old flags and `br_stall` is evaluated on the cycle-N `cnt`.
- Counter latency: `set_issue` in cycle N → `flags_pending=1` from cycle N+1.
- Single writeback with `cnt==1` in cycle N → `flags_pending=0` and `br_stall=0` in N+1. The branch resolves in N+1 using the new flags.
- Outputs `Zero`, `Pos`, `Neg`, `flags_pending` and `err` are registered. `issue_ready` and `br_stall` are combinational.

## Test plan
- Reset, then `br_query=1` → `Zero=1`, `Pos=0`, `Neg=0`, `br_stall=0`, `issue_ready=1`, `err=0`.
- Issue opcode 00010 in cycle 1; writeback `wb_result=16'h8000` in cycle 3; `br_query` held high:
  - `br_stall=1` in cycles 2–3;
  - cycle 4: `Neg=1`, `Zero=0`, `Pos=0`, `br_stall=0`.
- Issue three flag-setters with no writebacks:
  - `cnt=3`, and `issue_ready=0` on the 4th attempt;
  - same cycle as a `wb_valid` of 16'h0005: `issue_ready=1`, `cnt` stays 3, next cycle `Pos=1`.
- Issue branch opcode 01100 and opcode 10010 → `cnt` unchanged, `flags_pending` stays 0.
- `cnt=2`, `flush` together with `wb_valid` of 16'h0000 and a same-cycle `set_issue`:
  - next cycle `cnt=0`, `Zero=1`, `err=0`, `flags_pending=0`.
- `cnt=0`, `wb_valid` of 16'hFFFF → `Neg=1`, `err=1`, `cnt=0`.
  - `err` stays 1 across later normal traffic until `rst_n=0` for one cycle.
